// File: rtl/clk_sw_pkg.sv
// Shared select encodings and control-FSM states for the 800M/500M/1000M clock switch.
package clk_sw_pkg;

  localparam logic [1:0] SEL_800M  = 2'b00;
  localparam logic [1:0] SEL_500M  = 2'b01;
  localparam logic [1:0] SEL_1000M = 2'b10;
  localparam logic [1:0] SEL_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic sel_is_legal(input logic [1:0] sel);
    return sel != SEL_RSVD;
  endfunction

endpackage

// File: rtl/clk_sel_ctrl_settle_timer.sv
// Loadable down-counter that parks at zero; tick flags the zero count.
module settle_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/clk_sel_ctrl.sv
// Request/handshake front end for the glitch-free clock switch: holds clk_sel through a
// settle window so the switch's synchronizers finish before the next retarget.
module clk_sel_ctrl
  import clk_sw_pkg::*;
#(
  parameter int         SETTLE_CYC = 64,
  parameter int         CNT_W      = 7,
  parameter logic [1:0] RST_SEL    = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  output logic [1:0] clk_sel,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] cur_sel
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_t state;
  logic   transfer;
  logic   start_settle;
  logic   tick;

  // req_ready is only high in IDLE, so a transfer implies the FSM is idle.
  assign transfer     = req_valid & req_ready;
  assign start_settle = transfer & sel_is_legal(req_sel) & (req_sel != cur_sel);

  settle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (start_settle),
    .value(SETTLE_LOAD),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      clk_sel   <= RST_SEL;
      cur_sel   <= RST_SEL;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            if (!sel_is_legal(req_sel)) begin
              err <= 1'b1;
            end else if (req_sel == cur_sel) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              req_ready <= 1'b0;
            end else begin
              state     <= ST_SETTLE;
              clk_sel   <= req_sel;
              busy      <= 1'b1;
              req_ready <= 1'b0;
            end
          end
        end
        ST_SETTLE: begin
          if (tick) begin
            state   <= ST_DONE;
            cur_sel <= clk_sel;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Scoreboard bench for clk_sel_ctrl with a short settle window.
module tb_clk_sel_ctrl;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_sel = 2'b00;
  logic       req_ready;
  logic [1:0] clk_sel;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] cur_sel;

  typedef struct {
    bit         is_err;
    int         cyc;
    logic [1:0] sel;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] model_cur = 2'b00;

  clk_sel_ctrl #(
    .SETTLE_CYC(SETTLE),
    .CNT_W     (3),
    .RST_SEL   (2'b00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_sel  (req_sel),
    .req_ready(req_ready),
    .clk_sel  (clk_sel),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cur_sel  (cur_sel)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Present a request from a negedge; returns the cycle index of the transfer edge.
  task automatic accept_req(input logic [1:0] sel, input bit hold, output int t);
    bit   ok;
    exp_t e;
    ok        = 1'b0;
    t         = -1;
    req_valid = 1'b1;
    req_sel   = sel;
    for (int i = 0; i < 200; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end else begin
      t = cyc;
      if (sel == 2'b11) begin
        e = '{is_err: 1'b1, cyc: t + 1, sel: model_cur};
      end else if (sel == model_cur) begin
        e = '{is_err: 1'b0, cyc: t + 1, sel: sel};
      end else begin
        e = '{is_err: 1'b0, cyc: t + SETTLE + 1, sel: sel};
        model_cur = sel;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  // Wait (from the current negedge) for the next done/err pulse and check it against the scoreboard.
  task automatic wait_result(input string name);
    bit   seen;
    bit   viol;
    exp_t e;
    seen = 1'b0;
    viol = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ((busy & req_ready) || (done & err)) viol = 1'b1;
      if (done === 1'b1 || err === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!seen || sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL %s_timeout: no done/err pulse seen, %0d pending", name, sb.size());
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (err !== e.is_err || done !== !e.is_err) begin
      n_fail++;
      $display("[TB] FAIL %s_kind: done=%b err=%b required err=%b", name, done, err, e.is_err);
    end
    n_checks++;
    if (cyc != e.cyc) begin
      n_fail++;
      $display("[TB] FAIL %s_latency: pulse at cycle %0d required %0d", name, cyc, e.cyc);
    end
    n_checks++;
    if (cur_sel !== e.sel || (!e.is_err && clk_sel !== e.sel)) begin
      n_fail++;
      $display("[TB] FAIL %s_sel: cur_sel=%b clk_sel=%b required %b", name, cur_sel, clk_sel, e.sel);
    end
    n_checks++;
    if (viol) begin
      n_fail++;
      $display("[TB] FAIL %s_exclusive: busy&req_ready or done&err seen=1 required 0", name);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({clk_sel, cur_sel, req_ready, busy, done, err} !== {2'b00, 2'b00, 4'b1000}) begin
      n_fail++;
      $display("[TB] FAIL reset_values: clk_sel=%b cur_sel=%b rdy=%b busy=%b done=%b err=%b required 00 00 1 0 0 0",
               clk_sel, cur_sel, req_ready, busy, done, err);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_cur = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_legal_change();
    int  t;
    bit  bad;
    accept_req(2'b01, 1'b0, t);
    bad = 1'b0;
    for (int k = 1; k <= SETTLE; k++) begin
      if (busy !== 1'b1 || req_ready !== 1'b0 || clk_sel !== 2'b01 || done !== 1'b0) bad = 1'b1;
      if (k < SETTLE) @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("[TB] FAIL legal_settle: busy=%b rdy=%b clk_sel=%b required 1 0 01", busy, req_ready, clk_sel);
    end
    @(negedge clk);
    wait_result("legal");
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || cur_sel !== 2'b01 || cyc != t + SETTLE + 2) begin
      n_fail++;
      $display("[TB] FAIL legal_ready: rdy=%b busy=%b cur_sel=%b cyc=%0d required 1 0 01 %0d",
               req_ready, busy, cur_sel, cyc, t + SETTLE + 2);
    end
  endtask

  task automatic test_same_select();
    int t;
    accept_req(2'b01, 1'b0, t);
    n_checks++;
    if (busy !== 1'b0 || clk_sel !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL same_sel_quiet: busy=%b clk_sel=%b required 0 01", busy, clk_sel);
    end
    wait_result("same_sel");
    @(negedge clk);
  endtask

  task automatic test_reserved();
    int t;
    accept_req(2'b11, 1'b0, t);
    wait_result("reserved");
    n_checks++;
    if (clk_sel !== 2'b01 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reserved_hold: clk_sel=%b rdy=%b busy=%b required 01 1 0", clk_sel, req_ready, busy);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reserved_pulse: err=%b done=%b required 0 0", err, done);
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    accept_req(2'b10, 1'b1, t1);
    @(negedge clk);
    req_sel = 2'b00;
    @(negedge clk);
    n_checks++;
    if (clk_sel !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL held_frozen: clk_sel=%b required 10", clk_sel);
    end
    @(negedge clk);
    wait_result("held_first");
    @(negedge clk);
    accept_req(2'b00, 1'b0, t2);
    n_checks++;
    if (t2 - t1 != SETTLE + 2) begin
      n_fail++;
      $display("[TB] FAIL held_spacing: spacing %0d required %0d", t2 - t1, SETTLE + 2);
    end
    n_checks++;
    if (clk_sel !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL held_second_sel: clk_sel=%b required 00", clk_sel);
    end
    wait_result("held_second");
    @(negedge clk);
  endtask

  task automatic test_reset_mid_settle();
    int t;
    bit active;
    accept_req(2'b10, 1'b0, t);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (clk_sel !== 2'b00 || busy !== 1'b0 || cur_sel !== 2'b00 || req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_reset: clk_sel=%b busy=%b cur_sel=%b rdy=%b required 00 0 00 1",
               clk_sel, busy, cur_sel, req_ready);
    end
    sb.delete();
    model_cur = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    active = 1'b0;
    for (int k = 0; k < 2 * SETTLE + 4; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || clk_sel !== 2'b00) active = 1'b1;
    end
    n_checks++;
    if (active) begin
      n_fail++;
      $display("[TB] FAIL abort_quiet: output activity=1 required 0");
    end
    accept_req(2'b01, 1'b0, t);
    wait_result("after_abort");
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] clk_sel_ctrl bench start");
    test_reset();
    test_legal_change();
    test_same_select();
    test_reserved();
    test_back_to_back();
    test_reset_mid_settle();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
